// File: rtl/gomoku_input_pkg.sv
// Shared constants for the Gomoku button input path: state encoding and
// default debounce/auto-repeat timing at the 100 MHz system clock.
package gomoku_input_pkg;

  localparam int CLK_HZ            = 100_000_000;
  localparam int STABLE_CYCLES_DEF = CLK_HZ / 100;  // 10 ms
  localparam int REPEAT_DELAY_DEF  = CLK_HZ / 2;    // 500 ms
  localparam int REPEAT_PERIOD_DEF = CLK_HZ / 10;   // 100 ms

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_PRESS_DB   = 3'd1;
  localparam logic [2:0] ST_HELD_WAIT  = 3'd2;
  localparam logic [2:0] ST_REPEAT     = 3'd3;
  localparam logic [2:0] ST_RELEASE_DB = 3'd4;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Saturating up-counter with clear/enable; done flags that the next
// increment would reach the limit, so the owner can act on that same edge.
module cycle_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk_100mhz,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] limit,
  output logic             done
);

  logic [WIDTH-1:0] count;
  logic [WIDTH:0]   count_inc;

  assign count_inc = {1'b0, count} + {{WIDTH{1'b0}}, 1'b1};
  assign done      = (count_inc >= {1'b0, limit});

  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != {WIDTH{1'b1}})) begin
      count <= count_inc[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/btn_pulse_conditioner.sv
// Debounces the synchronized button level and emits press, release and
// auto-repeat strobes for the cursor/placement logic.
//
// state         | meaning
// IDLE          | button released, level 0
// PRESS_DB      | counting consecutive 1 samples toward acceptance
// HELD_WAIT     | pressed, waiting for the first auto-repeat
// REPEAT        | pressed, repeating every REPEAT_PERIOD cycles
// RELEASE_DB    | counting consecutive 0 samples; repeat count frozen
module btn_pulse_conditioner
  import gomoku_input_pkg::*;
#(
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF,
  parameter int REPEAT_EN     = 1
) (
  input  logic clk_100mhz,
  input  logic rst_n,
  input  logic btn_sync,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse
);

  localparam int CW = $clog2(max3(STABLE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)) + 1;
  localparam logic [CW-1:0] STABLE_LIM = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] DELAY_LIM  = CW'(REPEAT_DELAY);
  localparam logic [CW-1:0] PERIOD_LIM = CW'(REPEAT_PERIOD);

  logic [2:0]    state, state_nxt;
  logic          stab_clr, stab_en, stab_done;
  logic          rep_clr, rep_en, rep_done;
  logic [CW-1:0] rep_lim;
  logic          level_nxt, press_nxt, release_nxt, repeat_nxt;

  assign rep_lim = (state == ST_REPEAT) ? PERIOD_LIM : DELAY_LIM;

  cycle_timer #(.WIDTH(CW)) u_stable_timer (
    .clk_100mhz (clk_100mhz),
    .rst_n      (rst_n),
    .clear      (stab_clr),
    .enable     (stab_en),
    .limit      (STABLE_LIM),
    .done       (stab_done)
  );

  cycle_timer #(.WIDTH(CW)) u_repeat_timer (
    .clk_100mhz (clk_100mhz),
    .rst_n      (rst_n),
    .clear      (rep_clr),
    .enable     (rep_en),
    .limit      (rep_lim),
    .done       (rep_done)
  );

  always_comb begin
    state_nxt   = state;
    stab_clr    = 1'b0;
    stab_en     = 1'b0;
    rep_clr     = 1'b0;
    rep_en      = 1'b0;
    level_nxt   = btn_level;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    repeat_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        rep_clr = 1'b1;
        if (btn_sync) begin
          state_nxt = ST_PRESS_DB;
          stab_en   = 1'b1;
        end else begin
          stab_clr = 1'b1;
        end
      end
      ST_PRESS_DB: begin
        rep_clr = 1'b1;
        if (!btn_sync) begin
          state_nxt = ST_IDLE;
          stab_clr  = 1'b1;
        end else if (stab_done) begin
          state_nxt = ST_HELD_WAIT;
          stab_clr  = 1'b1;
          level_nxt = 1'b1;
          press_nxt = 1'b1;
        end else begin
          stab_en = 1'b1;
        end
      end
      ST_HELD_WAIT, ST_REPEAT: begin
        // A drop on the edge a repeat falls due wins; the repeat count freezes.
        if (!btn_sync) begin
          state_nxt = ST_RELEASE_DB;
          stab_en   = 1'b1;
        end else begin
          stab_clr = 1'b1;
          if (rep_done && (REPEAT_EN != 0)) begin
            state_nxt  = ST_REPEAT;
            rep_clr    = 1'b1;
            repeat_nxt = 1'b1;
          end else begin
            rep_en = 1'b1;
          end
        end
      end
      ST_RELEASE_DB: begin
        if (btn_sync) begin
          state_nxt = ST_HELD_WAIT;
          stab_clr  = 1'b1;
          rep_clr   = 1'b1;
        end else if (stab_done) begin
          state_nxt   = ST_IDLE;
          stab_clr    = 1'b1;
          rep_clr     = 1'b1;
          level_nxt   = 1'b0;
          release_nxt = 1'b1;
        end else begin
          stab_en = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        stab_clr  = 1'b1;
        rep_clr   = 1'b1;
        level_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      repeat_pulse  <= 1'b0;
    end else begin
      state         <= state_nxt;
      btn_level     <= level_nxt;
      press_pulse   <= press_nxt;
      release_pulse <= release_nxt;
      repeat_pulse  <= repeat_nxt;
    end
  end

endmodule

// File: tb/tb_btn_pulse_conditioner.sv
// Self-checking bench: vector table, hand sequences for glitch, release
// bounce and async reset, plus random stimulus against a behavioural model.
module tb_btn_pulse_conditioner;

  localparam int S = 4;
  localparam int D = 10;
  localparam int P = 5;

  logic clk_100mhz = 1'b0;
  logic rst_n      = 1'b0;
  logic btn_sync   = 1'b0;
  logic lvl_a, prs_a, rel_a, rep_a;
  logic lvl_b, prs_b, rel_b, rep_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_100mhz = ~clk_100mhz;

  btn_pulse_conditioner #(
    .STABLE_CYCLES(S), .REPEAT_DELAY(D), .REPEAT_PERIOD(P), .REPEAT_EN(1)
  ) dut_a (
    .clk_100mhz    (clk_100mhz),
    .rst_n         (rst_n),
    .btn_sync      (btn_sync),
    .btn_level     (lvl_a),
    .press_pulse   (prs_a),
    .release_pulse (rel_a),
    .repeat_pulse  (rep_a)
  );

  btn_pulse_conditioner #(
    .STABLE_CYCLES(S), .REPEAT_DELAY(D), .REPEAT_PERIOD(P), .REPEAT_EN(0)
  ) dut_b (
    .clk_100mhz    (clk_100mhz),
    .rst_n         (rst_n),
    .btn_sync      (btn_sync),
    .btn_level     (lvl_b),
    .press_pulse   (prs_b),
    .release_pulse (rel_b),
    .repeat_pulse  (rep_b)
  );

  typedef struct {
    logic       btn;
    logic [3:0] exp;
  } vec_t;

  // Behavioural view: accepted level, run of opposite samples, cycles held
  // since the last press/bounce/repeat, and whether the next repeat is the first.
  typedef struct {
    bit level;
    int run;
    int held;
    bit first;
  } model_t;

  vec_t   vecs[38];
  model_t ma, mb;

  function automatic logic [3:0] out_a();
    return {lvl_a, prs_a, rel_a, rep_a};
  endfunction

  function automatic logic [3:0] out_b();
    return {lvl_b, prs_b, rel_b, rep_b};
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (level,press,release,repeat) at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic b);
    btn_sync = b;
    @(posedge clk_100mhz);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    btn_sync = 1'b0;
    ma       = '{default: 0};
    mb       = '{default: 0};
    repeat (2) @(posedge clk_100mhz);
    #2;
    rst_n = 1'b1;
    check("reset_a", out_a(), 4'b0000);
    check("reset_b", out_b(), 4'b0000);
  endtask

  task automatic model_step(input logic s, input bit en, inout model_t m, output logic [3:0] e);
    bit pr, rl, rp;
    int due;
    pr = 1'b0;
    rl = 1'b0;
    rp = 1'b0;
    if (s != m.level) begin
      m.run++;
      if (m.run == S) begin
        m.level = s;
        m.run   = 0;
        if (s) begin
          pr      = 1'b1;
          m.held  = 0;
          m.first = 1'b1;
        end else begin
          rl = 1'b1;
        end
      end
    end else begin
      if (m.level) begin
        if (m.run > 0) begin
          m.held  = 0;
          m.first = 1'b1;
        end else begin
          m.held++;
          due = m.first ? D : P;
          if (en && m.held == due) begin
            rp      = 1'b1;
            m.held  = 0;
            m.first = 1'b0;
          end
        end
      end
      m.run = 0;
    end
    e = {m.level, pr, rl, rp};
  endtask

  initial begin
    int         b_press, b_repeat, len;
    logic       val;
    logic [3:0] ea, eb;

    for (int i = 0; i < 38; i++) begin
      vecs[i].btn = (i < 30);
      vecs[i].exp = {(i >= 3 && i < 33), (i == 3), (i == 33),
                     (i == 13 || i == 18 || i == 23 || i == 28)};
    end

    // Hold 30 cycles then release; dut_b (no repeat) is tallied alongside.
    do_reset();
    b_press  = 0;
    b_repeat = 0;
    for (int i = 0; i < 38; i++) begin
      step(vecs[i].btn);
      check($sformatf("table[%0d]", i), out_a(), vecs[i].exp);
      b_press  += int'(prs_b);
      b_repeat += int'(rep_b);
    end
    check_int("no_repeat_press_count", b_press, 1);
    check_int("no_repeat_repeat_count", b_repeat, 0);

    // Glitch shorter than the stable count.
    do_reset();
    for (int i = 0; i < 23; i++) begin
      step(i < 3);
      check($sformatf("glitch[%0d]", i), out_a(), 4'b0000);
    end

    // Release bounce: 0,0,1 then zeros; only the 4th zero after the bounce releases.
    do_reset();
    for (int i = 0; i < 23; i++) begin
      step(i <= 5 || i == 8);
      check($sformatf("bounce[%0d]", i), out_a(),
            {(i >= 3 && i < 12), (i == 3), (i == 12), 1'b0});
    end

    // Async reset mid-hold, then requalify with the button still down.
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1);
    check("held_before_reset", out_a(), 4'b1000);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_a", out_a(), 4'b0000);
    check("async_reset_b", out_b(), 4'b0000);
    @(posedge clk_100mhz);
    #2;
    rst_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step(1'b1);
      check($sformatf("post_reset[%0d]", k), out_a(),
            (k == 4) ? 4'b1100 : ((k == 5) ? 4'b1000 : 4'b0000));
    end

    // Random runs of mixed length against the behavioural model.
    do_reset();
    len = 0;
    val = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (len == 0) begin
        val = ~val;
        len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 40))
                                          : int'($urandom_range(1, 5));
      end
      len--;
      step(val);
      model_step(val, 1'b1, ma, ea);
      model_step(val, 1'b0, mb, eb);
      check("rand_a", out_a(), ea);
      check("rand_b", out_b(), eb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/btn_pulse_conditioner.md
Name: btn_pulse_conditioner

Overview:
- Sits directly downstream of the 2-flop switch/button synchronizer.
- Consumes the already-synchronized button level and rejects bounce with a stable-count filter.
- Produces a clean level plus one-cycle press, release and auto-repeat strobes for the Gomoku cursor/placement logic.
- Single clock domain (clk_100mhz); no further synchronization is done here.

Parameters:
- STABLE_CYCLES, 1_000_000: consecutive identical samples needed to accept a level change (10 ms at 100 MHz). Legal values are 2 and above.
- REPEAT_DELAY, 50_000_000: cycles from press_pulse to the first repeat_pulse (500 ms). Legal values are 1 and above.
- REPEAT_PERIOD, 10_000_000: cycles between subsequent repeat_pulse strobes (100 ms). Legal values are 2 and above.
- REPEAT_EN, 1: 1 enables auto-repeat; 0 suppresses repeat_pulse entirely.

Ports:
- clk_100mhz  in   1  system clock, 100 MHz
- rst_n       in   1  asynchronous reset, active-low. The block has one clock and an asynchronous active-low reset.
- btn_sync    in   1  synchronized raw button level, from the synchronizer
- btn_level   out  1  debounced level
- press_pulse out  1  one-cycle strobe on accepted 0->1
- release_pulse out 1 one-cycle strobe on accepted 1->0
- repeat_pulse out 1  one-cycle strobe while held, after delay

Behaviour:
- All outputs are registered.
- Reset (rst_n=0, asynchronous):
  - State goes to IDLE, all counters to 0, all outputs to 0 immediately.
  - No release_pulse is generated by reset.
- Counters:
  - Width is $clog2 of the largest parameter, plus 1.
  - Counters saturate and never wrap.
- State machine, states IDLE, PRESS_DB, HELD_WAIT, REPEAT, RELEASE_DB:
  - IDLE (btn_level=0): btn_sync=1 moves to PRESS_DB with stable count 1; otherwise stay.
  - PRESS_DB: btn_sync=0 returns to IDLE with no output change (glitch rejected).
  - PRESS_DB, press accepted: on the edge that takes the STABLE_CYCLES-th consecutive 1 sample, move to HELD_WAIT. On that edge btn_level<=1 and press_pulse<=1 for exactly one cycle; the repeat counter clears.
  - HELD_WAIT: the repeat counter increments every cycle. When it reaches REPEAT_DELAY and REPEAT_EN=1, repeat_pulse<=1 for one cycle, move to REPEAT, counter clears.
  - REPEAT: repeat_pulse fires every REPEAT_PERIOD cycles.
  - HELD_WAIT/REPEAT, btn_sync=0: move to RELEASE_DB with stable count 1. The repeat counter freezes and no repeat pulses occur in RELEASE_DB.
  - RELEASE_DB: btn_sync=1 before the count completes returns to HELD_WAIT with the repeat counter cleared. A bounce therefore restarts the repeat cadence; btn_level stays 1 and no pulses are issued.
  - RELEASE_DB, release accepted: on the STABLE_CYCLES-th consecutive 0 sample, move to IDLE with btn_level<=0 and release_pulse<=1 for one cycle.
- Press latency: if the first 1 is sampled at edge k and the input stays high, btn_level and press_pulse become visible after edge k+STABLE_CYCLES-1.
- Mutual exclusion: press_pulse, release_pulse and repeat_pulse are never asserted in the same cycle. A repeat due on the same edge that btn_sync drops is suppressed.
- REPEAT_EN=0: HELD_WAIT exits only to RELEASE_DB.
- Reset mid-hold: after rst_n rises with the button still held, a full STABLE_CYCLES qualification is required and a fresh press_pulse is produced.

Decomposition:
- Shared package gomoku_input_pkg holds:
  - the state encoding localparams (3-bit);
  - the default timing constants (10 ms, 500 ms, 100 ms in cycles at 100 MHz);
  - a CLK_HZ constant.
- One natural sub-module, cycle_timer:
  - saturating up-counter with clear, enable and a compare-to-limit done flag;
  - instantiated twice, once for the stable count and once for the repeat count.

Test Plan (STABLE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5, REPEAT_EN=1 unless noted):
- Clean press: btn_sync=1 from edge 0 onward -> btn_level=1 and press_pulse high for one cycle after edge 3; no other pulses through edge 12.
- Glitch: btn_sync=1 for edges 0-2, then 0 -> btn_level stays 0, no pulses for 20 cycles.
- Hold 30 cycles: press_pulse after edge 3; repeat_pulse after edges 13, 18, 23, 28; each pulse exactly one cycle wide.
- Release bounce: after acceptance, btn_sync=0 for 2 cycles, 1 for 1 cycle, then 0 for 4 cycles -> btn_level falls and release_pulse fires after the 4th zero only. No repeat_pulse occurs within 10 cycles after the bounce.
- Async reset mid-hold: drop rst_n between edges -> all outputs 0 without waiting for a clock edge. Release rst_n with btn_sync=1 -> press_pulse again after the 4th post-reset edge.
- REPEAT_EN=0, hold 30 cycles -> exactly one press_pulse and zero repeat_pulse.
